voxel_access_initiator: RTL

Client-side initiator for the voxel cache request interface. It accepts voxel commands (read, write, accumulate) from the LiDAR feature pipeline over a valid/ready stream. It drives the cache's voxel_addr/voxel_data_in/read_en/write_en strobes and waits for the cache's one-cycle ready pulse. Accumulate is a read-modify-write with a saturating add. Each command returns one response on a valid/ready stream, with a timeout guard on every cache access.

---
 rtl/voxel_access_initiator.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/voxel_access_initiator.sv
// Purpose: client-side initiator turning read/write/accumulate commands into voxel cache strobes.
// Latency: hit read accept->rsp_valid 3 cycles, hit accumulate 5 cycles; each cache wait bounded by TIMEOUT_CYCLES.
// Backpressure: one command outstanding; req_ready only in IDLE, response held until rsp_valid&&rsp_ready.
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/ready/op/addr/data - command stream (op 00 rd, 01 wr, 10 acc, 11 reserved)
//   cache_addr/wdata/read_en/write_en - registered drive into the cache
//   cache_rdata/ready     - cache completion pulse and read data
//   rsp_valid/ready/data/err - response stream
//   timeout_sticky        - latched on any cache timeout until reset
module voxel_access_initiator #(
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              cache_read_en,
    output logic              cache_write_en,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              timeout_sticky
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter is 0 in the first wait cycle, i.e. one cycle after the
    // strobe. Giving up when it holds TIMEOUT_CYCLES-2 lands RESP exactly
    // TIMEOUT_CYCLES cycles after the strobe.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        WR_ISSUE,
        WR_WAIT,
        RESP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic               is_acc;
    logic [DATA_W-1:0]  addend;

    logic               accept;
    logic               rd_hit;
    logic               wr_hit;
    logic               tmo;

    logic [DATA_W:0]    sum_full;
    logic [DATA_W-1:0]  sum_sat;

    assign sum_full = {1'b0, cache_rdata} + {1'b0, addend};
    assign sum_sat  = sum_full[DATA_W] ? {DATA_W{1'b1}} : sum_full[DATA_W-1:0];

    // req_ready is forced low while rst is asserted so nothing is accepted
    // on the cycle reset releases.
    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        rd_hit  = 1'b0;
        wr_hit  = 1'b0;
        tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    case (req_op)
                        OP_RD, OP_ACC: state_n = RD_ISSUE;
                        OP_WR:         state_n = WR_ISSUE;
                        default:       state_n = RESP;
                    endcase
                end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT: begin
                if (cache_ready) begin
                    rd_hit  = 1'b1;
                    state_n = is_acc ? WR_ISSUE : RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_n = RESP;
                end
            end
            WR_ISSUE: state_n = WR_WAIT;
            WR_WAIT: begin
                if (cache_ready) begin
                    wr_hit  = 1'b1;
                    state_n = RESP;
                end else if (wait_cnt == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wait_cnt       <= '0;
            is_acc         <= 1'b0;
            addend         <= '0;
            cache_addr     <= '0;
            cache_wdata    <= '0;
            cache_read_en  <= 1'b0;
            cache_write_en <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            state <= state_n;

            // Strobes follow the issue states one-for-one, so they can never
            // overlap and last exactly one cycle.
            cache_read_en  <= (state_n == RD_ISSUE);
            cache_write_en <= (state_n == WR_ISSUE);

            if (state == RD_WAIT || state == WR_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (accept) begin
                cache_addr <= req_addr;
                is_acc     <= (req_op == OP_ACC);
                addend     <= req_data;
                rsp_data   <= '0;
                rsp_err    <= (req_op == 2'b11);
                if (req_op == OP_WR) begin
                    cache_wdata <= req_data;
                end
            end

            if (rd_hit) begin
                if (is_acc) begin
                    cache_wdata <= sum_sat;
                end else begin
                    rsp_data <= cache_rdata;
                end
            end

            if (wr_hit) begin
                rsp_data <= cache_wdata;
            end

            if (tmo) begin
                rsp_data       <= '0;
                rsp_err        <= 1'b1;
                timeout_sticky <= 1'b1;
            end
        end
    end

endmodule
